// File: rtl/ram64_fifo_ctrl.sv
// Valid/ready FIFO built on an external 64x16 single-port RAM plus a one-word output register.
// Optional build macro RAM64_FIFO_BYPASS_EN lets a push into an empty FIFO skip the RAM.
module ram64_fifo_ctrl #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [WIDTH-1:0]  wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [WIDTH-1:0]  rd_data,
  output logic [WIDTH-1:0]  ram_in,
  output logic              ram_load,
  output logic [ADDR_W-1:0] ram_address,
  input  logic [WIDTH-1:0]  ram_out,
  output logic [ADDR_W:0]   level
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic [WIDTH-1:0]  r_rd_data;
  logic              r_rd_valid;

  logic w_out_free;
  logic w_fetch;
  logic w_push;
  logic w_bypass;
  logic w_push_ram;
  logic w_pop;

  // The output stage can take a word when it is empty or being emptied this cycle.
  assign w_out_free = !r_rd_valid || rd_ready;
  assign w_fetch    = (r_count != '0) && w_out_free;
  assign w_pop      = r_rd_valid && rd_ready;

  always_comb begin
    wr_ready = rst_n && (r_count != FULL_CNT) && !w_fetch;
  end

  assign w_push = wr_valid && wr_ready;

`ifdef RAM64_FIFO_BYPASS_EN
  assign w_bypass = w_push && (r_count == '0) && w_out_free;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push_ram = w_push && !w_bypass;

  always_comb begin
    ram_in      = wr_data;
    ram_load    = w_push_ram;
    ram_address = w_push_ram ? r_wr_ptr : r_rd_ptr;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      // Fetch and RAM push are mutually exclusive, so count moves by at most one.
      if (w_fetch) begin
        r_rd_data  <= ram_out;
        r_rd_valid <= 1'b1;
        r_rd_ptr   <= r_rd_ptr + ADDR_W'(1);
        r_count    <= r_count - (ADDR_W + 1)'(1);
      end else if (w_bypass) begin
        r_rd_data  <= wr_data;
        r_rd_valid <= 1'b1;
      end else if (w_pop) begin
        r_rd_valid <= 1'b0;
      end
      if (w_push_ram) begin
        r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
        r_count  <= r_count + (ADDR_W + 1)'(1);
      end
    end
  end

  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_data;
  assign level    = r_count + {{ADDR_W{1'b0}}, r_rd_valid};

endmodule

// File: tb/tb_ram64_fifo_ctrl.sv
// Scoreboard bench for ram64_fifo_ctrl with a behavioural RAM64 attached.
module tb_ram64_fifo_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_data;
  logic        rd_valid;
  logic        rd_ready;
  logic [15:0] rd_data;
  logic [15:0] ram_in;
  logic        ram_load;
  logic [5:0]  ram_address;
  logic [15:0] ram_out;
  logic [6:0]  level;

  logic [15:0] mem [64];

  int checks = 0;
  int errors = 0;
  int pop_count = 0;
  int exp_level = 0;
  logic [15:0] last_pop = '0;
  logic [15:0] exp_q [$];

`ifdef RAM64_FIFO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  always #5 clk = ~clk;

  ram64_fifo_ctrl #(.WIDTH(16), .ADDR_W(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .ram_in(ram_in), .ram_load(ram_load), .ram_address(ram_address),
    .ram_out(ram_out), .level(level)
  );

  always @(posedge clk) if (ram_load) mem[ram_address] <= ram_in;
  assign ram_out = mem[ram_address];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: handshakes are observed mid-cycle, away from the active edge.
  initial begin
    logic        hold;
    logic [15:0] held;
    hold = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        exp_level = 0;
        hold = 1'b0;
      end else begin
        chk("level", 32'(level), 32'(exp_level));
        if (hold && rd_valid) chk("rd_data_stable", 32'(rd_data), 32'(held));
        if (rd_valid && rd_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pop_underflow: got %0h expected nothing", rd_data);
          end else begin
            chk("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
          end
          last_pop = rd_data;
          pop_count++;
          exp_level--;
        end
        if (wr_valid && wr_ready) begin
          exp_q.push_back(wr_data);
          exp_level++;
        end
        hold = rd_valid && !rd_ready;
        held = rd_data;
      end
    end
  end

  task automatic push_word(input logic [15:0] d);
    int unsigned n;
    n = 0;
    wr_valid = 1'b1;
    wr_data  = d;
    forever begin
      @(negedge clk);
      if (wr_ready) break;
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL push_timeout: got wr_ready=0 expected 1 for %0h", d);
        break;
      end
    end
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
  endtask

  task automatic drain(input string name, output int unsigned cycles);
    cycles = 0;
    rd_ready = 1'b1;
    while (level != 0 && cycles < 400) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    rd_ready = 1'b0;
    chk(name, 32'(level), 32'd0);
  endtask

  initial begin
    int unsigned n;
    int base;
    rst_n    = 1'b0;
    wr_valid = 1'b1;
    wr_data  = 16'hffff;
    rd_ready = 1'b0;

    // Reset with a pending write: nothing may reach the RAM.
    @(negedge clk);
    chk("reset_ram_load", 32'(ram_load), 32'd0);
    chk("reset_wr_ready", 32'(wr_ready), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wr_valid = 1'b0;
    @(negedge clk);
    chk("idle_rd_valid", 32'(rd_valid), 32'd0);
    chk("idle_level", 32'(level), 32'd0);
    chk("idle_wr_ready", 32'(wr_ready), 32'd1);

    // Single word latency.
    @(posedge clk);
    #1;
    wr_valid = 1'b1;
    wr_data  = 16'h0001;
    @(negedge clk);
    chk("single_wr_ready", 32'(wr_ready), 32'd1);
    chk("single_ram_load", 32'(ram_load), BYP ? 32'd0 : 32'd1);
    if (!BYP) chk("single_ram_addr", 32'(ram_address), 32'd0);
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    @(negedge clk);
    chk("single_rd_valid_e1", 32'(rd_valid), BYP ? 32'd1 : 32'd0);
    if (BYP) chk("single_no_load", 32'(ram_load), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("single_rd_valid_e2", 32'(rd_valid), 32'd1);
    chk("single_rd_data", 32'(rd_data), 32'h0001);
    @(posedge clk);
    #1;
    rd_ready = 1'b1;
    @(posedge clk);
    #1;
    rd_ready = 1'b0;
    @(negedge clk);
    chk("single_empty_level", 32'(level), 32'd0);
    chk("single_empty_valid", 32'(rd_valid), 32'd0);
    @(posedge clk);
    #1;

    // Fill to 65 with the consumer stalled.
    for (int i = 0; i <= 64; i++) push_word(16'h2000 + 16'(i));
    @(negedge clk);
    chk("full_level", 32'(level), 32'd65);
    chk("full_wr_ready", 32'(wr_ready), 32'd0);
    chk("full_head", 32'(rd_data), 32'h2000);
    @(posedge clk);
    #1;
    wr_valid = 1'b1;
    wr_data  = 16'hdead;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("full_reject", 32'(wr_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    wr_valid = 1'b0;

    // Drain at full rate: one word per cycle.
    drain("drain_level", n);
    chk("drain_cycles", n, 32'd65);

    // Random traffic across pointer wrap.
    void'($urandom(32'd1234));
    base = pop_count;
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          push_word(16'h4000 + 16'(i));
        end
      end
      begin
        int unsigned k;
        k = 0;
        while (pop_count - base < 100 && k < 3000) begin
          @(posedge clk);
          #1;
          rd_ready = 1'($urandom_range(0, 1));
          k++;
        end
        rd_ready = 1'b0;
      end
    join
    chk("wrap_pops", 32'(pop_count - base), 32'd100);
    chk("wrap_queue", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a stream discards everything.
    for (int i = 0; i < 10; i++) push_word(16'h6000 + 16'(i));
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_level", 32'(level), 32'd0);
    chk("midrst_rd_valid", 32'(rd_valid), 32'd0);
    @(posedge clk);
    #1;
    base = pop_count;
    push_word(16'h7063);
    drain("midrst_drain", n);
    chk("midrst_pops", 32'(pop_count - base), 32'd1);
    chk("midrst_data", 32'(last_pop), 32'h7063);
    chk("final_queue", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1);
  end

endmodule
